// File: rtl/ram_bist_pkg.sv
// Shared types and per-element constants for the March C- RAM BIST.
// Bit i of each element mask describes march element Mi.
package ram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        DRAIN,
        DONE
    } bist_state_e;

    localparam int FAIL_CNT_W = 8;

    localparam logic [5:0] ELEM_DOWN      = 6'b011000;
    localparam logic [5:0] ELEM_HAS_READ  = 6'b111110;
    localparam logic [5:0] ELEM_HAS_WRITE = 6'b011111;
    localparam logic [5:0] READ_BG        = 6'b010100;
    localparam logic [5:0] WRITE_BG       = 6'b001010;

    // Non-element states (IDLE, DRAIN, DONE) read as 0 for every mask.
    function automatic logic elem_flag(logic [5:0] mask, bist_state_e s);
        logic f;
        f = 1'b0;
        case (s)
            M0:      f = mask[0];
            M1:      f = mask[1];
            M2:      f = mask[2];
            M3:      f = mask[3];
            M4:      f = mask[4];
            M5:      f = mask[5];
            default: f = 1'b0;
        endcase
        return f;
    endfunction

    function automatic bist_state_e next_elem(bist_state_e s);
        bist_state_e n;
        n = DONE;
        case (s)
            M0:      n = M1;
            M1:      n = M2;
            M2:      n = M3;
            M3:      n = M4;
            M4:      n = M5;
            M5:      n = DRAIN;
            default: n = DONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march elements with a terminal-count flag.
// The direction is latched on init so the flag always refers to the running element.
module ram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  init_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  at_end
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic down;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
            down <= 1'b0;
        end else if (init) begin
            down <= init_down;
            addr <= init_down ? LAST_ADDR : '0;
        end else if (step) begin
            addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
    end

    assign at_end = down ? (addr == '0) : (addr == LAST_ADDR);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST controller driving the single-port synchronous RAM port.
// Define RAM_BIST_STOP_ON_FAIL_EN to end the run at the first recorded mismatch.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    bist_state_e state, state_nxt;
    logic phase, phase_nxt;
    logic addr_init, addr_init_down, addr_step, at_end;
    logic two_op, rd_now, accept, mismatch, stop_now;
    logic wr_nxt, busy_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic cmp_valid, cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;

    ram_bist_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (addr_init),
        .init_down(addr_init_down),
        .step     (addr_step),
        .addr     (mem_addr),
        .at_end   (at_end)
    );

    assign two_op   = elem_flag(ELEM_HAS_READ, state) && elem_flag(ELEM_HAS_WRITE, state);
    assign rd_now   = elem_flag(ELEM_HAS_READ, state) && !(two_op && phase);
    assign accept   = start && (state == IDLE || state == DONE);
    assign mismatch = cmp_valid && (mem_data_out != {DATA_WIDTH{cmp_exp}});

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // Read/write pairs share one address; the counter only moves after the write.
    always_comb begin
        state_nxt      = state;
        phase_nxt      = 1'b0;
        addr_init      = 1'b0;
        addr_init_down = 1'b0;
        addr_step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                addr_init = 1'b1;
                if (start) begin
                    state_nxt = M0;
                end
            end
            DRAIN: begin
                addr_init = 1'b1;
                state_nxt = DONE;
            end
            default: begin
                if (two_op && !phase) begin
                    phase_nxt = 1'b1;
                end else if (at_end) begin
                    state_nxt      = next_elem(state);
                    addr_init      = 1'b1;
                    addr_init_down = elem_flag(ELEM_DOWN, next_elem(state));
                end else begin
                    addr_step = 1'b1;
                end
            end
        endcase
        if (stop_now) begin
            state_nxt      = DONE;
            phase_nxt      = 1'b0;
            addr_init      = 1'b1;
            addr_init_down = 1'b0;
            addr_step      = 1'b0;
        end
    end

    always_comb begin
        wr_nxt   = elem_flag(ELEM_HAS_WRITE, state_nxt);
        data_nxt = '0;
        busy_nxt = 1'b1;
        if (elem_flag(ELEM_HAS_READ, state_nxt) && elem_flag(ELEM_HAS_WRITE, state_nxt)) begin
            wr_nxt = phase_nxt;
        end
        if (wr_nxt) begin
            data_nxt = {DATA_WIDTH{elem_flag(WRITE_BG, state_nxt)}};
        end
        if (state_nxt == IDLE || state_nxt == DONE) begin
            busy_nxt = 1'b0;
        end
    end

    // A read queued at the stop edge is dropped so DONE never records late data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_count  <= '0;
            mem_write   <= 1'b0;
            mem_data_in <= '0;
            cmp_valid   <= 1'b0;
            cmp_exp     <= 1'b0;
            cmp_addr    <= '0;
        end else begin
            busy        <= busy_nxt;
            done        <= (state_nxt == DONE);
            mem_write   <= wr_nxt;
            mem_data_in <= data_nxt;
            cmp_valid   <= rd_now && (state_nxt != DONE);
            cmp_exp     <= elem_flag(READ_BG, state);
            cmp_addr    <= mem_addr;
            if (accept) begin
                pass       <= 1'b1;
                fail_addr  <= '0;
                fail_count <= '0;
            end else if (mismatch) begin
                pass <= 1'b0;
                if (fail_count == '0) begin
                    fail_addr <= cmp_addr;
                end
                if (fail_count != '1) begin
                    fail_count <= fail_count + FAIL_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Randomized stuck-at fault bench for ram_march_bist against a March C- reference model.
// Honours RAM_BIST_STOP_ON_FAIL_EN when computing expected results.
module tb_ram_march_bist;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic busy0, done0, pass0, mw0;
    logic [7:0] fa0, fc0, ma0, md0, mo0;
    logic busy1, done1, pass1, mw1;
    logic [7:0] fa1, fc1, ma1, md1, mo1;

    logic [7:0] ram0 [256];
    logic [7:0] ram1 [256];

    bit fault_en = 1'b0;
    logic [7:0] fault_addr = 8'h00;
    int fault_bit = 0;
    bit fault_val = 1'b0;

    int n_compared = 0;
    int n_mismatched = 0;
    int trace_err = 0;
    int max_addr = 0;
    int last_cyc = 0;

    always #5 clk = ~clk;

    ram_march_bist #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_addr(fa0), .fail_count(fc0), .mem_write(mw0),
        .mem_addr(ma0), .mem_data_in(md0), .mem_data_out(mo0)
    );

    ram_march_bist #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_addr(fa1), .fail_count(fc1), .mem_write(mw1),
        .mem_addr(ma1), .mem_data_in(md1), .mem_data_out(mo1)
    );

    function automatic logic [7:0] applyFault(input logic [7:0] v, input logic [7:0] a);
        logic [7:0] r;
        r = v;
        if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
        return r;
    endfunction

    // Synchronous RAMs: data_out is valid the cycle after the address is presented.
    always @(posedge clk) begin
        if (mw0) ram0[ma0] <= md0;
        mo0 <= applyFault(ram0[ma0], ma0);
        if (mw1) ram1[ma1] <= md1;
        mo1 <= ram1[ma1];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Op k (1-based) of March C-: {w0}up {r0,w1}up {r1,w0}up {r0,w1}dn {r1,w0}dn {r0}up.
    function automatic void refOp(input int k, input int depth, output bit wr, output int addr,
                                  output logic [7:0] data, output logic [7:0] expv);
        int j;
        int a;
        j = k - 1;
        wr = 1'b0;
        addr = 0;
        data = 8'h00;
        expv = 8'h00;
        if (j < depth) begin
            wr = 1'b1;
            addr = j;
            return;
        end
        j -= depth;
        for (int e = 1; e <= 4; e++) begin
            if (j < 2 * depth) begin
                a = j / 2;
                wr = (j % 2) == 1;
                addr = (e >= 3) ? depth - 1 - a : a;
                expv = (e % 2 == 0) ? 8'hFF : 8'h00;
                data = (e % 2 == 1) ? 8'hFF : 8'h00;
                return;
            end
            j -= 2 * depth;
        end
        addr = j;
    endfunction

    task automatic refMarch(input int depth, input bit stop, output int cyc, output bit p,
                            output logic [7:0] faddr, output int fcnt);
        logic [7:0] mdl [256];
        bit wr;
        int a;
        logic [7:0] d, ex, rd;
        for (int i = 0; i < 256; i++) mdl[i] = 8'($urandom);
        p = 1'b1;
        faddr = 8'h00;
        fcnt = 0;
        cyc = 10 * depth + 1;
        for (int k = 1; k <= 10 * depth; k++) begin
            refOp(k, depth, wr, a, d, ex);
            if (wr) begin
                mdl[a] = d;
            end else begin
                rd = applyFault(mdl[a], 8'(a));
                if (rd != ex) begin
                    if (fcnt == 0) faddr = 8'(a);
                    if (fcnt < 255) fcnt++;
                    p = 1'b0;
                    if (stop) begin
                        cyc = k + 1;
                        return;
                    end
                end
            end
        end
    endtask

    // Pulse start, follow the run cycle by cycle, return cycles from E0 to done.
    task automatic applyStimulus(input int sel, input int depth, input int restart_at,
                                 input int reset_at, output int cyc);
        int c;
        bit wr;
        int a;
        logic [7:0] d, ex, ma, md;
        logic b, dn, w;
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        c = 0;
        cyc = -1;
        while (c < 30000) begin
            b  = sel ? busy1 : busy0;
            dn = sel ? done1 : done0;
            w  = sel ? mw1 : mw0;
            ma = sel ? ma1 : ma0;
            md = sel ? md1 : md0;
            if (dn) begin
                cyc = c;
                break;
            end
            if (!b) trace_err++;
            if (c < 10 * depth) begin
                refOp(c + 1, depth, wr, a, d, ex);
                if (w != wr || ma != 8'(a) || (wr && md != d)) trace_err++;
            end
            if (int'(ma) > max_addr) max_addr = int'(ma);
            if (c == restart_at) begin
                if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
            end
            if (c == reset_at) rst_n = 1'b0;
            @(posedge clk);
            #1;
            c++;
            start0 = 1'b0;
            start1 = 1'b0;
            if (reset_at >= 0 && c == reset_at + 1) begin
                rst_n = 1'b1;
                cyc = c;
                return;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            b  = sel ? busy1 : busy0;
            w  = sel ? mw1 : mw0;
            ma = sel ? ma1 : ma0;
            md = sel ? md1 : md0;
            if (b || w || ma != 8'h00 || md != 8'h00) trace_err++;
        end
    endtask

    task automatic runMarch(input string tag, input int restart_at);
        int cyc, ecyc, efc;
        bit ep;
        logic [7:0] efa;
        refMarch(256, STOP, ecyc, ep, efa, efc);
        trace_err = 0;
        applyStimulus(0, 256, restart_at, -1, cyc);
        last_cyc = cyc;
        checkOutput({tag, "_cycles"}, 64'(cyc), 64'(ecyc));
        checkOutput({tag, "_pass"}, 64'(pass0), 64'(ep));
        checkOutput({tag, "_fail_addr"}, 64'(fa0), 64'(efa));
        checkOutput({tag, "_fail_count"}, 64'(fc0), 64'(efc));
        checkOutput({tag, "_port_trace"}, 64'(trace_err), 64'd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs0", 64'({busy0, done0, pass0, fa0, fc0, mw0, ma0, md0}), 64'd0);
        checkOutput("reset_outs1", 64'({busy1, done1, pass1, fa1, fc1, mw1, ma1, md1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fault_en = 1'b0;
        runMarch("clean", -1);
        checkOutput("clean_done_at", 64'(last_cyc), 64'd2561);

        fault_en = 1'b1;
        fault_addr = 8'h37;
        fault_bit = 0;
        fault_val = 1'b1;
        runMarch("sa1_37", -1);
        checkOutput("sa1_37_addr_const", 64'(fa0), 64'h37);
        checkOutput("sa1_37_count_const", 64'(fc0), STOP ? 64'd1 : 64'd3);
        checkOutput("sa1_37_done_const", 64'(last_cyc), STOP ? 64'd368 : 64'd2561);

        runMarch("restart_ignored", 100);
        runMarch("rerun", -1);

        for (int i = 0; i < 4; i++) begin
            fault_addr = 8'($urandom_range(0, 255));
            fault_bit = $urandom_range(0, 7);
            fault_val = 1'($urandom_range(0, 1));
            $display("[TB] random fault %0d: addr 0x%0h bit %0d stuck at %0d", i, fault_addr,
                     fault_bit, fault_val);
            runMarch($sformatf("rand%0d", i), -1);
        end

        fault_en = 1'b0;
        trace_err = 0;
        applyStimulus(0, 256, -1, 1000, cyc);
        checkOutput("midrun_reset_edge", 64'(cyc), 64'd1001);
        checkOutput("midrun_reset_outs", 64'({busy0, done0, pass0, fa0, fc0, mw0, ma0, md0}), 64'd0);
        checkOutput("midrun_reset_trace", 64'(trace_err), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("midrun_reset_idle", 64'({busy0, done0, pass0, fa0, fc0, mw0, ma0, md0}), 64'd0);
        runMarch("after_reset", -1);

        trace_err = 0;
        max_addr = 0;
        applyStimulus(1, 16, -1, -1, cyc);
        checkOutput("d16_cycles", 64'(cyc), 64'd161);
        checkOutput("d16_pass", 64'(pass1), 64'd1);
        checkOutput("d16_fail_count", 64'(fc1), 64'd0);
        checkOutput("d16_fail_addr", 64'(fa1), 64'd0);
        checkOutput("d16_max_addr", 64'(max_addr), 64'd15);
        checkOutput("d16_port_trace", 64'(trace_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
